fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It replaces the bare PC register and PC+4 adder. It owns the fetch PC and issues word requests to an instruction memory with 1+ cycle read latency. Returned instructions are buffered in a DEPTH-entry prefetch queue, so decode can stall without stalling memory. A branch/jump redirect flushes the queue and discards the in-flight response.

Parameters:
XLEN, 32, instruction/PC width in bits
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset; word aligned

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  request valid this cycle (combinational)
imem_addr  out  XLEN-2  word address, fetch_pc[XLEN-1:2]
imem_valid  in  1  response valid; at most one outstanding request
imem_rdata  in  XLEN  returned instruction word
redirect_valid  in  1  taken branch/jump from decode
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, forced to 0
instr_ready  in  1  decode accepts head entry (the inverse of StallD)
instr_valid  out  1  queue head valid (count != 0)
instr_out  out  XLEN  head instruction; 32'h0 (NOP) when empty
pc_plus4_out  out  XLEN  head entry PC + 4
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=IDLE. instr_valid=0, instr_out=0, pc_plus4_out=0, imem_req=0 in the reset cycle.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding.
  - DROP: one request outstanding, its response is to be discarded.
- slots_used = count + (state != IDLE). A response arriving this cycle counts as outstanding. Same-cycle pops are ignored (conservative).
- issue = !reset && !redirect_valid && slots_used < DEPTH && (state==IDLE || (state==WAIT && imem_valid)).
  - On issue: imem_req=1, imem_addr=fetch_pc[XLEN-1:2], fetch_pc <= fetch_pc+4 (mod 2^XLEN), state <= WAIT.
- Transitions:
  - WAIT & imem_valid & !issue -> IDLE.
  - DROP & imem_valid -> IDLE; data discarded, no issue that cycle.
  - Any state & redirect_valid: fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; queue flushed (count=0, pointers reset); state <= DROP if a request is outstanding and imem_valid=0, else IDLE.
- Push: in WAIT with imem_valid & !redirect_valid, write {imem_rdata, req_pc+4} at the write pointer. req_pc is latched at issue.
- Pop: instr_valid & instr_ready & !redirect_valid advances the read pointer.
- Simultaneous push+pop: count unchanged.
- Overflow is impossible by construction; the bench asserts push never occurs when count==DEPTH.
- Latency (1-cycle memory):
  - Request in cycle N -> instr_valid in cycle N+2.
  - Sustained 1 instruction/cycle while instr_ready=1.
- Redirect has priority over push, pop and issue. The first request to the new PC is issued the next cycle (IDLE) or after the dropped response (DROP).
- Redirect while the queue is empty and nothing is outstanding: fetch_pc updated only.
- Reset asserted mid-operation: returns to reset state immediately. A late imem_valid after reset is ignored (state IDLE).

Decomposition:
- Package cpu_pkg holds:
  - XLEN
  - NOP_INSTR=32'h0
  - RESET_PC default
  - fetch FSM state enum
- One sub-module: sync_fifo (DEPTH x (2*XLEN), push/pop/flush, count, head data). fetch_queue holds the FSM, PC and credit logic.

Test Plan:
- Reset with RESET_PC=0, 1-cycle memory, ready=1 -> addr 0,1,2,... on consecutive cycles; instr_valid from cycle 2; pc_plus4_out 4,8,12.
- instr_ready=0 for 10 cycles -> count saturates at 4; imem_req=0 once slots_used=4. Ready reasserted -> four instructions drained in order, fetch resumes with no gap or duplicate.
- redirect_valid with redirect_pc=32'h0000_0103 while a request is outstanding -> queue flushed, next response dropped, next imem_addr=32'h40, pc_plus4_out=32'h104.
- Memory latency 3 cycles, ready=1 -> one request per 3 cycles, never two outstanding, output order preserved.
- Redirect in the same cycle as imem_valid -> response discarded, count=0, state IDLE, issue to the new PC next cycle.
- fetch_pc=32'hFFFF_FFFC issue -> next imem_addr=0; reset asserted mid-stream -> count=0, instr_valid=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   XLEN       : instruction / PC width in bits
//   NOP_INSTR  : encoding presented to decode when the prefetch queue is empty
//   RESET_PC   : default fetch address after reset
//   fetch_state_t : fetch FSM states (request tracking)
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // IDLE: nothing outstanding
  // WAIT: one request outstanding, its response is kept
  // DROP: one request outstanding, its response is discarded (redirected)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch front end's handshakes: instruction-memory request /
// response, redirect from decode, and the instruction stream to decode.
//   master : the fetch_queue side (drives requests and the decode stream)
//   slave  : the environment side (memory, decode)
interface fetch_queue_if #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            imem_req;
  logic [XLEN-3:0] imem_addr;
  logic            imem_valid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_ready;
  logic            instr_valid;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_plus4_out;
  logic [CW-1:0]   count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_plus4_out, count,
    input  imem_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_plus4_out, count,
    output imem_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, used as the prefetch queue.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the queue (pointers and count to zero)
//   push/wdata : write one entry (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   rdata      : head entry, combinational
//   count      : current occupancy
module sync_fifo #(
  parameter int DEPTH = 4,   // power of two
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates its
  // visibility, and leaving it unreset lets it map onto plain RAM/regfile.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one word request at a
// time to an instruction memory of arbitrary (>=1 cycle) latency, and buffers
// returned words in a DEPTH-entry prefetch queue so decode can stall without
// stalling memory. A redirect flushes the queue and discards any in-flight
// response.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_queue_if.master (memory, redirect and decode handshakes)
module fetch_queue #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
  input  logic           clk,
  input  logic           reset,
  fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  cpu_pkg::fetch_state_t state, state_next;

  logic [XLEN-1:0]   fetch_pc, fetch_pc_next;
  logic [XLEN-1:0]   req_pc;
  logic [CW-1:0]     fill;
  logic [CW:0]       slots_used;
  logic [2*XLEN-1:0] head;
  logic              issue, push, pop;

  // Credit check: queued entries plus the outstanding request (including one
  // whose response lands this cycle). Same-cycle pops are not credited, which
  // keeps the issue path independent of decode's ready.
  assign slots_used = {1'b0, fill} + (CW+1)'(state != cpu_pkg::IDLE);

  assign issue = !reset && !bus.redirect_valid
              && (slots_used < (CW+1)'(DEPTH))
              && (state == cpu_pkg::IDLE
                  || (state == cpu_pkg::WAIT && bus.imem_valid));

  assign push = !reset && !bus.redirect_valid
             && state == cpu_pkg::WAIT && bus.imem_valid;

  assign pop  = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (bus.redirect_valid) begin
      fetch_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
      // A request still in flight must have its response swallowed.
      if (state != cpu_pkg::IDLE && !bus.imem_valid) state_next = cpu_pkg::DROP;
      else                                           state_next = cpu_pkg::IDLE;
    end else if (issue) begin
      fetch_pc_next = fetch_pc + XLEN'(4);
      state_next    = cpu_pkg::WAIT;
    end else if (bus.imem_valid && state != cpu_pkg::IDLE) begin
      state_next = cpu_pkg::IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= cpu_pkg::IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (issue) req_pc <= fetch_pc;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.imem_rdata, req_pc + XLEN'(4)}),
    .rdata (head),
    .count (fill)
  );

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = fetch_pc[XLEN-1:2];
  assign bus.count        = fill;
  // Reset masks the head immediately, even if the queue still held entries.
  assign bus.instr_valid  = !reset && (fill != '0);
  assign bus.instr_out    = bus.instr_valid ? head[2*XLEN-1:XLEN]
                                            : XLEN'(cpu_pkg::NOP_INSTR);
  assign bus.pc_plus4_out = bus.instr_valid ? head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural instruction memory with
// selectable latency, a program-order tracker for issued addresses and popped
// instructions, and hand-computed checks for each scenario.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  // memory model state
  logic        mem_pending = 1'b0;
  logic [29:0] mem_addr    = '0;
  int          mem_due     = 0;

  // program-order expectations
  logic [29:0] exp_issue = RESET_PC[31:2];
  logic [29:0] exp_pop   = RESET_PC[31:2];

  // per-cycle snapshot of DUT outputs
  logic        o_req, o_valid;
  logic [29:0] o_addr;
  logic [31:0] o_instr, o_pc4;
  logic [2:0]  o_count;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return {2'b10, wa};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: memory response, control inputs, then sample outputs.
  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic rdy);
    logic [31:0] e_pc4;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_pending && mem_due == cyc) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = mem_word(mem_addr);
      mem_pending    = 1'b0;
    end else begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
    reset              = rst;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    #1;
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_valid = bus.instr_valid;
    o_instr = bus.instr_out;
    o_pc4   = bus.pc_plus4_out;
    o_count = bus.count;

    check("no_overflow", dut.push && (o_count == 3'(DEPTH)), 1'b0);
    check("valid_vs_count", o_valid, !rst && (o_count != 3'd0));
    if (o_req) begin
      check("single_outstanding", mem_pending, 1'b0);
      check("issue_addr", o_addr, exp_issue);
      mem_pending = 1'b1;
      mem_addr    = o_addr;
      mem_due     = cyc + lat;
      exp_issue   = exp_issue + 30'd1;
    end
    if (!o_valid) begin
      check("nop_when_empty", {o_instr, o_pc4}, 64'd0);
    end else if (rdy && !redir && !rst) begin
      e_pc4 = {exp_pop, 2'b00} + 32'd4;
      check("pop_instr", o_instr, mem_word(exp_pop));
      check("pop_pc4", o_pc4, e_pc4);
      exp_pop = exp_pop + 30'd1;
    end
    if (rst) begin
      exp_issue = RESET_PC[31:2];
      exp_pop   = RESET_PC[31:2];
    end else if (redir) begin
      exp_issue = rpc[31:2];
      exp_pop   = rpc[31:2];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev;
    bus.imem_valid     = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    // ---- reset state
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("reset_req", o_req, 1'b0);
    check("reset_valid", o_valid, 1'b0);
    check("reset_instr", o_instr, 32'h0);
    check("reset_pc4", o_pc4, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("reset_count", o_count, 3'd0);

    // ---- 1-cycle memory, decode always ready
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_req_c0", o_req, 1'b1);
    check("t1_addr_c0", o_addr, 30'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_addr_c1", o_addr, 30'd1);
    check("t1_valid_c1", o_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_valid_c2", o_valid, 1'b1);
    check("t1_pc4_c2", o_pc4, 32'd4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_pc4_c3", o_pc4, 32'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_pc4_c4", o_pc4, 32'd12);

    // ---- decode stalls for 10 cycles: queue fills, requests stop
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_count_full", o_count, 3'd4);
    check("t2_req_stopped", o_req, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("t2_no_gap", o_valid, 1'b1);
    end

    // ---- 3-cycle memory: one request every 3 cycles
    lat  = 3;
    prev = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (o_req) begin
        if (prev != 0) check("t4_spacing", cyc - prev, 3);
        prev = cyc;
      end
    end

    // ---- redirect while a request is outstanding -> response dropped
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!o_req && n < 10);
    check("t3_found_req", o_req, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_flush_count", o_count, 3'd0);
    check("t3_flush_valid", o_valid, 1'b0);
    check("t3_no_req_drop", o_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_no_req_resp", o_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_req_new", o_req, 1'b1);
    check("t3_addr_new", o_addr, 30'h40);
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!o_valid && n < 10);
    check("t3_pc4", o_pc4, 32'h0000_0104);
    check("t3_instr", o_instr, mem_word(30'h40));

    // ---- redirect in the same cycle as the response
    n = 0;
    while (!(mem_pending && mem_due == cyc + 1) && n < 10) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check("t5_found_resp", mem_pending && (mem_due == cyc + 1), 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check("t5_resp_present", bus.imem_valid, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_count", o_count, 3'd0);
    check("t5_req", o_req, 1'b1);
    check("t5_addr", o_addr, 30'h80);

    // ---- PC wrap-around at the top of the address space
    lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!o_req && n < 10);
    check("t6_addr_top", o_addr, 30'h3FFF_FFFF);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_req_wrap", o_req, 1'b1);
    check("t6_addr_wrap", o_addr, 30'h0);
    n = 0;
    while (!o_valid && n < 10) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check("t6_pc4_wrap", o_pc4, 32'h0);
    check("t6_instr_top", o_instr, mem_word(30'h3FFF_FFFF));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // ---- reset mid-stream
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("t7_rst_valid", o_valid, 1'b0);
    check("t7_rst_req", o_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t7_count", o_count, 3'd0);
    check("t7_valid", o_valid, 1'b0);
    check("t7_req", o_req, 1'b1);
    check("t7_addr", o_addr, RESET_PC[31:2]);
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!o_valid && n < 10);
    check("t7_restart_pc4", o_pc4, RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
